seq_bitwise_unit: RTL and testbench

- Parametrised, multi-cycle bitwise logic unit. Generalises the fixed 32-bit AND built from 4-bit slices.
- A single SLICE-wide logic slice is reused over WIDTH/SLICE cycles, one slice per cycle, LSB slice first.
- Selectable operation: AND, OR, XOR or NOR.
- Sits beside the ALU as a low-area logic path, with a valid/ready handshake on the input side and on the output side.

---
 rtl/seq_bitwise_unit.sv | 124 ++++++++++++
 tb/tb_seq_bitwise_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seq_bitwise_unit.sv
// seq_bitwise_unit
//   Multi-cycle bitwise logic unit. One SLICE-wide logic slice is reused
//   over WIDTH/SLICE cycles, LSB slice first, to compute AND/OR/XOR/NOR of
//   two WIDTH-bit operands. Valid/ready handshake on both sides.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands/op valid
//   in_ready   unit idle and able to accept (combinational from state)
//   op         00 AND, 01 OR, 10 XOR, 11 NOR
//   a, b       operands
//   out_valid  r/zero hold a completed result
//   out_ready  consumer accepts the result
//   r          result register
//   zero       r == 0, meaningful while out_valid = 1
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready = 1
// BUSY  | writing one slice of r per cycle from the latched operands
// DONE  | result held with out_valid = 1 until out_ready

module seq_bitwise_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
      $error("seq_bitwise_unit: WIDTH must be an integer multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_nxt;

  function automatic logic [SLICE-1:0] slice_op(input logic [1:0]       o,
                                                input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Only the slice selected by cnt changes; the compare-per-slice form keeps
  // the slice select legal for any NSLICE, including NSLICE = 1.
  always_comb begin
    r_nxt = r;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) begin
        r_nxt[i*SLICE +: SLICE] = slice_op(op_q, a_q[i*SLICE +: SLICE], b_q[i*SLICE +: SLICE]);
      end
    end
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            r     <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          r <= r_nxt;
          if (cnt == CW'(NSLICE - 1)) begin
            // flag from the completed value, so it is valid together with out_valid
            zero      <= (r_nxt == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bitwise_unit.sv
module tb_seq_bitwise_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default 32/4 instance
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [1:0]  op;
  logic [31:0] a, b, r;

  // 16/16 instance
  logic        in_valid16, in_ready16, out_valid16, out_ready16, zero16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, r16;

  // 64/8 instance
  logic        in_valid64, in_ready64, out_valid64, out_ready64, zero64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, r64;

  int total = 0;
  int bad   = 0;

  seq_bitwise_unit #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .r(r), .zero(zero));

  seq_bitwise_unit #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .r(r16), .zero(zero16));

  seq_bitwise_unit #(.WIDTH(64), .SLICE(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .op(op64),
    .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64), .r(r64), .zero(zero64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // full transaction on the 32-bit unit; starts and ends 1 time unit after an edge
  task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_r, input logic exp_z);
    int cyc;
    chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd8);
    chk({tag, "_r"}, 64'(r), 64'(exp_r));
    chk({tag, "_zero"}, 64'(zero), 64'(exp_z));
    chk({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    in_valid = 0; out_ready = 0; op = 0; a = 0; b = 0;
    in_valid16 = 0; out_ready16 = 0; op16 = 0; a16 = 0; b16 = 0;
    in_valid64 = 0; out_ready64 = 0; op64 = 0; a64 = 0; b64 = 0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_r", 64'(r), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    rst = 1'b0;
    step();

    run32("and1", 2'b00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0);
    run32("or",   2'b01, 32'hAAAA_5555, 32'hFFFF_0000, 32'hFFFF_5555, 1'b0);
    run32("xor",  2'b10, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
    run32("nor",  2'b11, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0000_AAAA, 1'b0);
    run32("and2", 2'b00, 32'hAAAA_5555, 32'hFFFF_0000, 32'hAAAA_0000, 1'b0);
    run32("xor_zero", 2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1);
    run32("and_one",  2'b00, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 1'b0);

    // backpressure with inputs perturbed throughout BUSY and DONE: OR of latched operands
    op = 2'b01; a = 32'h0000_FFFF; b = 32'h1200_0000; in_valid = 1'b1;
    step();
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      op = 2'($urandom); a = $urandom; b = $urandom; in_valid = ~in_valid;
      chk("bp_in_ready_busy", 64'(in_ready), 64'd0);
      step();
      cyc++;
    end
    chk("bp_latency", 64'(cyc), 64'd8);
    for (int i = 0; i < 5; i++) begin
      op = 2'($urandom); a = $urandom; b = $urandom; in_valid = ~in_valid;
      chk("bp_hold_r", 64'(r), 64'h1200_FFFF);
      chk("bp_hold_zero", 64'(zero), 64'd0);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_handoff_valid", 64'(out_valid), 64'd0);
    chk("bp_handoff_in_ready", 64'(in_ready), 64'd1);
    step();

    // reset sampled at the 4th BUSY edge, with early slices already nonzero
    op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_partial_r", 64'(r), 64'h0000_0FFF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_r", 64'(r), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 10; i++) step();
    chk("mid_no_result", 64'(out_valid), 64'd0);
    run32("after_rst", 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001, 1'b0);

    // WIDTH=16 SLICE=16: single-cycle busy
    op16 = 2'b01; a16 = 16'hF0F0; b16 = 16'h0FF0; in_valid16 = 1'b1;
    step();
    in_valid16 = 1'b0;
    cyc = 0;
    while (!out_valid16 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("w16_latency", 64'(cyc), 64'd1);
    chk("w16_r", 64'(r16), 64'h0000_FFF0);
    chk("w16_zero", 64'(zero16), 64'd0);
    out_ready16 = 1'b1;
    step();
    out_ready16 = 1'b0;
    chk("w16_in_ready_back", 64'(in_ready16), 64'd1);

    // WIDTH=64 SLICE=8: eight busy cycles
    op64 = 2'b10; a64 = 64'hFFFF_FFFF_0000_0000; b64 = 64'h0F0F_0F0F_0F0F_0F0F; in_valid64 = 1'b1;
    step();
    in_valid64 = 1'b0;
    cyc = 0;
    while (!out_valid64 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("w64_latency", 64'(cyc), 64'd8);
    chk("w64_r", r64, 64'hF0F0_F0F0_0F0F_0F0F);
    chk("w64_zero", 64'(zero64), 64'd0);
    out_ready64 = 1'b1;
    step();
    out_ready64 = 1'b0;
    chk("w64_in_ready_back", 64'(in_ready64), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
